cv32e40x_xif_offload_ctrl: RTL

CV32E40X_XIF_OFFLOAD_CTRL -- requirements
Module: cv32e40x_xif_offload_ctrl

---
 rtl/cv32e40x_xif_offload_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_xif_offload_ctrl.sv
// Offload controller between the core pipeline and an eXtension-interface coprocessor.
// Optional result timeout enabled by defining CV32E40X_XIF_OFFLOAD_TIMEOUT_EN.
module cv32e40x_xif_offload_ctrl #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_RFR_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs2_i,
  input  logic [1:0]             req_rs_valid_i,
  input  logic                   kill_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [1:0]             issue_rs_valid_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [4:0]             result_rd_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  input  logic                   result_we_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   illegal_o,
  output logic                   err_o,
  output logic                   timeout_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCommit} state_e;

  state_e                  state_q;
  logic [31:0]             instr_q;
  logic [X_RFR_WIDTH-1:0]  rs0_q, rs1_q;
  logic [1:0]              rs_valid_q;
  logic [X_ID_WIDTH-1:0]   id_q, commit_id_q;
  logic                    accept_q, writeback_q;

  logic [MAX_OUTSTANDING-1:0] sb_valid_q, sb_valid_d, clr_oh, free_oh;
  logic [X_ID_WIDTH-1:0]      sb_id_q [MAX_OUTSTANDING];
  logic [CntW-1:0]            count_q, count_d;
  logic                       res_hs, res_hit, free_found, sb_set, sb_clr, tmo_fire;

  assign res_hs = result_valid_i & wb_ready_i;
  assign sb_clr = res_hs & res_hit;
  assign sb_set = (state_q == StCommit) & accept_q & writeback_q & ~kill_i;

  // Only the first matching entry clears, so a duplicated ID retires one entry per result.
  always_comb begin
    clr_oh     = '0;
    free_oh    = '0;
    res_hit    = 1'b0;
    free_found = 1'b0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (!res_hit && sb_valid_q[i] && (sb_id_q[i] == result_id_i)) begin
        clr_oh[i] = 1'b1;
        res_hit   = 1'b1;
      end
      if (!free_found && !sb_valid_q[i]) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    sb_valid_d = sb_valid_q;
    if (sb_clr) sb_valid_d = sb_valid_d & ~clr_oh;
    if (tmo_fire) sb_valid_d = '0;
    if (sb_set) sb_valid_d = sb_valid_d | free_oh;
    count_d = count_q;
    if (tmo_fire) begin
      count_d = sb_set ? CntW'(1) : '0;
    end else if (sb_set && !sb_clr) begin
      count_d = count_q + CntW'(1);
    end else if (!sb_set && sb_clr) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_q     <= '0;
      rs0_q       <= '0;
      rs1_q       <= '0;
      rs_valid_q  <= '0;
      id_q        <= '0;
      commit_id_q <= '0;
      accept_q    <= 1'b0;
      writeback_q <= 1'b0;
      sb_valid_q  <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) sb_id_q[i] <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      count_q    <= count_d;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (sb_set && free_oh[i]) sb_id_q[i] <= commit_id_q;
      end
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_o) begin
            instr_q    <= req_instr_i;
            rs0_q      <= req_rs1_i;
            rs1_q      <= req_rs2_i;
            rs_valid_q <= req_rs_valid_i;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (issue_ready_i) begin
            accept_q    <= issue_accept_i;
            writeback_q <= issue_writeback_i;
            commit_id_q <= id_q;
            id_q        <= id_q + X_ID_WIDTH'(1);
            state_q     <= StCommit;
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef CV32E40X_XIF_OFFLOAD_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (res_hs || (count_q == '0) || tmo_fire) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign tmo_fire = (tmo_q == 8'hFF);
`else
  assign tmo_fire = 1'b0;
`endif

  assign req_ready_o      = (state_q == StIdle) && (count_q < CntW'(MAX_OUTSTANDING));
  assign issue_valid_o    = (state_q == StIssue);
  assign issue_instr_o    = instr_q;
  assign issue_rs0_o      = rs0_q;
  assign issue_rs1_o      = rs1_q;
  assign issue_rs_valid_o = rs_valid_q;
  assign issue_id_o       = id_q;
  assign commit_valid_o   = (state_q == StCommit);
  assign commit_id_o      = commit_id_q;
  assign commit_kill_o    = commit_valid_o & (kill_i | ~accept_q);
  assign illegal_o        = commit_valid_o & ~accept_q;
  assign result_ready_o   = wb_ready_i;
  assign wb_valid_o       = sb_clr & result_we_i;
  assign wb_rd_o          = wb_valid_o ? result_rd_i : '0;
  assign wb_data_o        = wb_valid_o ? result_data_i : '0;
  assign err_o            = res_hs & ~res_hit;
  assign timeout_o        = tmo_fire;

endmodule
